// File: rtl/instruction_fetcher.sv
// instruction_fetcher: per-warp fetch stage with a one-entry last-fetch buffer and a request timeout
package instruction_fetcher_pkg;

    typedef enum logic [2:0] {
        WARP_IDLE,
        WARP_FETCH,
        WARP_DECODE,
        WARP_REQUEST,
        WARP_WAIT,
        WARP_EXECUTE,
        WARP_UPDATE,
        WARP_DONE
    } warp_state_t;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [15:0] imm;
    } instruction_t;

endpackage

module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int INSTR_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  warp_state_t            warp_state,
    input  logic [ADDR_WIDTH-1:0]  pc,
    input  logic                   flush,
    output logic                   mem_read_valid,
    output logic [ADDR_WIDTH-1:0]  mem_read_address,
    input  logic                   mem_read_ready,
    input  logic [INSTR_WIDTH-1:0] mem_read_data,
    output logic [1:0]             fetcher_state,
    output instruction_t           instruction,
    output logic                   fetch_error
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_REQUEST = 2'b01,
        S_DONE    = 2'b10
    } state_t;

    state_t                 state;
    logic                   buf_valid;
    logic [ADDR_WIDTH-1:0]  buf_pc;
    logic [INSTR_WIDTH-1:0] buf_data;
    logic [7:0]             count;

    logic hit;
    logic timeout;

    assign hit           = buf_valid && (buf_pc == pc) && !flush;
    assign timeout       = count == 8'(TIMEOUT_CYCLES - 1);
    assign fetcher_state = state;

    // Fetch FSM: buffer lookup, memory handshake with timeout, result hold until decode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            instruction      <= '0;
            fetch_error      <= 1'b0;
            buf_valid        <= 1'b0;
            buf_pc           <= '0;
            buf_data         <= '0;
            count            <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (warp_state == WARP_FETCH) begin
                        fetch_error <= 1'b0;
                        if (hit) begin
                            instruction <= instruction_t'(buf_data);
                            state       <= S_DONE;
                        end else begin
                            mem_read_valid   <= 1'b1;
                            mem_read_address <= pc;
                            count            <= '0;
                            state            <= S_REQUEST;
                        end
                    end
                end
                S_REQUEST: begin
                    if (mem_read_valid && mem_read_ready) begin
                        instruction    <= instruction_t'(mem_read_data);
                        buf_pc         <= mem_read_address;
                        buf_data       <= mem_read_data;
                        buf_valid      <= 1'b1;
                        mem_read_valid <= 1'b0;
                        state          <= S_DONE;
                    end else if (timeout) begin
                        mem_read_valid <= 1'b0;
                        instruction    <= '0;
                        fetch_error    <= 1'b1;
                        state          <= S_DONE;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                S_DONE: begin
                    if (warp_state == WARP_DECODE) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // A flush overrides any buffer fill on the same edge
            if (flush) buf_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_fetcher.sv
// tb_instruction_fetcher: randomized fetch traffic checked against a buffer/latency reference model
module tb_instruction_fetcher;
    import instruction_fetcher_pkg::*;

    localparam int T = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    warp_state_t  warp_state = WARP_IDLE;
    logic [31:0]  pc = '0;
    logic         flush = 1'b0;
    logic         mem_read_ready = 1'b0;
    logic [31:0]  mem_read_data = '0;
    logic         mem_read_valid;
    logic [31:0]  mem_read_address;
    logic [1:0]   fetcher_state;
    instruction_t instruction;
    logic         fetch_error;

    int errors = 0;
    int checks = 0;

    bit          mv = 1'b0;
    logic [31:0] mpc = '0;
    logic [31:0] mdata = '0;
    logic [31:0] last_instr = '0;
    bit          last_err = 1'b0;

    instruction_fetcher #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk),
        .reset(reset),
        .warp_state(warp_state),
        .pc(pc),
        .flush(flush),
        .mem_read_valid(mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data),
        .fetcher_state(fetcher_state),
        .instruction(instruction),
        .fetch_error(fetch_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete fetch: lat = cycle (1-based) in which ready is raised; lat > T means never
    task automatic fetch(input logic [31:0] a, input bit fl, input int lat, input logic [31:0] d, input bit fl_done);
        bit hit;
        int n;
        hit = mv && mpc == a && !fl;
        n = 0;
        @(negedge clk);
        warp_state = WARP_FETCH;
        pc = a;
        flush = fl;
        @(negedge clk);
        flush = 1'b0;
        warp_state = WARP_WAIT;
        pc = $urandom;
        if (fl) mv = 1'b0;
        if (hit) begin
            chk("hit_state", fetcher_state, 2);
            chk("hit_valid", mem_read_valid, 0);
            last_instr = mdata;
            last_err = 1'b0;
        end else begin
            chk("req_state", fetcher_state, 1);
            while (mem_read_valid === 1'b1 && n < T + 4) begin
                n++;
                chk("req_addr", mem_read_address, a);
                if (n == lat) begin
                    mem_read_ready = 1'b1;
                    mem_read_data = d;
                    flush = fl_done;
                end
                @(negedge clk);
                mem_read_ready = 1'b0;
                mem_read_data = $urandom;
                flush = 1'b0;
            end
            if (lat >= 1 && lat <= T) begin
                chk("valid_cycles", n, lat);
                last_instr = d;
                last_err = 1'b0;
                mv = !fl_done;
                mpc = a;
                mdata = d;
            end else begin
                chk("timeout_cycles", n, T);
                last_instr = '0;
                last_err = 1'b1;
            end
            chk("done_state", fetcher_state, 2);
        end
        chk("instr", instruction, last_instr);
        chk("err", fetch_error, last_err);
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk("hold_state", fetcher_state, 2);
            chk("hold_instr", instruction, last_instr);
        end
        warp_state = WARP_DECODE;
        @(negedge clk);
        warp_state = WARP_IDLE;
        chk("idle_state", fetcher_state, 0);
        chk("idle_instr", instruction, last_instr);
        chk("idle_err", fetch_error, last_err);
    endtask

    initial begin
        #1 reset = 1'b0;
        #1;
        chk("rst_valid", mem_read_valid, 0);
        chk("rst_addr", mem_read_address, 0);
        chk("rst_state", fetcher_state, 0);
        chk("rst_instr", instruction, 0);
        chk("rst_err", fetch_error, 0);
        @(negedge clk);
        reset = 1'b1;

        @(negedge clk);
        warp_state = WARP_FETCH;
        pc = 32'h40;
        @(negedge clk);
        warp_state = WARP_WAIT;
        chk("pre_rst_valid", mem_read_valid, 1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_valid", mem_read_valid, 0);
        chk("async_rst_state", fetcher_state, 0);
        mem_read_ready = 1'b1;
        mem_read_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 mem_read_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        warp_state = WARP_IDLE;
        @(negedge clk);
        chk("late_ready_instr", instruction, 0);
        chk("late_ready_state", fetcher_state, 0);
        chk("late_ready_valid", mem_read_valid, 0);
        mv = 1'b0;

        fetch(32'h10, 1'b0, 3, 32'h2000_4C21, 1'b0);
        fetch(32'h10, 1'b0, 3, 32'h1111_1111, 1'b0);
        fetch(32'h10, 1'b1, 2, 32'h2000_4C21, 1'b0);
        fetch(32'h20, 1'b0, 99, 32'h0, 1'b0);
        fetch(32'h14, 1'b0, 1, 32'h0000_1234, 1'b0);
        fetch(32'h24, 1'b0, T, 32'hE000_0007, 1'b0);
        fetch(32'h24, 1'b0, 1, 32'h5555_5555, 1'b0);
        fetch(32'h30, 1'b0, 2, 32'h3030_3030, 1'b1);
        fetch(32'h30, 1'b0, 1, 32'h3131_3131, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? $urandom : 32'h10 + 32'(4 * $urandom_range(0, 2));
            fetch(a, $urandom_range(0, 4) == 0, $urandom_range(1, T + 2), $urandom, $urandom_range(0, 4) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
